nn_layer_sequencer: RTL and testbench

- FSM controller that sequences the shared 15-slice MAC datapath through every layer of one feed-forward inference.
- Generates the shared ROM/RAM address (`cycle`), the accumulator clear, the result-RAM write enable and the datapath source selects.
- Adds a start/busy/done handshake so image capture logic can launch an inference and detect its completion.

---
 rtl/nn_layer_sequencer.sv | 128 ++++++++++++
 tb/tb_nn_layer_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer
// Walks the shared 15-slice MAC datapath through every layer of one
// feed-forward inference. It produces the shared ROM/RAM address, the
// accumulator clear, the result-RAM write strobe and the source selects.
// A start/busy/done handshake lets capture logic launch an inference and
// see when it has finished.
module nn_layer_sequencer #(
   parameter int ADR_LEN       = 9,
   parameter int NUM_LAYERS    = 3,
   parameter int INPUT_CYCLES  = 257,
   parameter int HIDDEN_CYCLES = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic [ADR_LEN-1:0] cycle,
   output logic               clear,
   output logic               we,
   output logic               rd_src1,
   output logic [1:0]         rd_src2,
   output logic [1:0]         layer
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      MAC   = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [ADR_LEN-1:0] INPUT_LAST  = ADR_LEN'(INPUT_CYCLES - 1);
   localparam logic [ADR_LEN-1:0] HIDDEN_LAST = ADR_LEN'(HIDDEN_CYCLES - 1);
   localparam logic [1:0]         LAST_LAYER  = 2'(NUM_LAYERS - 1);

   state_t             state_q, state_d;
   logic [ADR_LEN-1:0] cycle_q, cycle_d;
   logic [1:0]         layer_q, layer_d;
   logic [ADR_LEN-1:0] lastBeat;

   // Layer 0 integrates every pixel plus the bias row; later layers only
   // see the 15 hidden activations plus their bias row.
   assign lastBeat = (layer_q == 2'd0) ? INPUT_LAST : HIDDEN_LAST;

   // Next-state logic: abort drops everything and returns to an idle,
   // zeroed sequencer; otherwise step through clear/mac/write per layer.
   always_comb begin
      state_d = state_q;
      cycle_d = cycle_q;
      layer_d = layer_q;
      if (abort) begin
         state_d = IDLE;
         cycle_d = '0;
         layer_d = 2'd0;
      end else begin
         case (state_q)
            IDLE: begin
               cycle_d = '0;
               layer_d = 2'd0;
               if (start) begin
                  state_d = CLEAR;
               end
            end
            CLEAR: begin
               cycle_d = '0;
               state_d = MAC;
            end
            MAC: begin
               if (cycle_q == lastBeat) begin
                  cycle_d = '0;
                  state_d = WRITE;
               end else begin
                  cycle_d = cycle_q + ADR_LEN'(1);
               end
            end
            WRITE: begin
               cycle_d = '0;
               if (layer_q == LAST_LAYER) begin
                  state_d = DONE;
               end else begin
                  layer_d = layer_q + 2'd1;
                  state_d = CLEAR;
               end
            end
            DONE: begin
               cycle_d = '0;
               layer_d = 2'd0;
               state_d = IDLE;
            end
            default: begin
               cycle_d = '0;
               layer_d = 2'd0;
               state_d = IDLE;
            end
         endcase
      end
   end

   // State, address and layer registers; reset outranks abort and start.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cycle_q <= '0;
         layer_q <= 2'd0;
      end else begin
         state_q <= state_d;
         cycle_q <= cycle_d;
         layer_q <= layer_d;
      end
   end

   // Control strobes decode straight from the state; the accumulator is
   // held cleared whenever no products are being integrated.
   always_comb begin
      busy    = (state_q == CLEAR) || (state_q == MAC) || (state_q == WRITE);
      done    = (state_q == DONE);
      clear   = (state_q == IDLE) || (state_q == CLEAR) || (state_q == DONE);
      we      = (state_q == WRITE);
      rd_src1 = (layer_q != 2'd0);
      rd_src2 = layer_q;
      cycle   = cycle_q;
      layer   = layer_q;
   end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb_nn_layer_sequencer
// Directed bench for the layer sequencer. Expected outputs for every cycle
// come from the published inference timeline, are queued as each step is
// driven, and are popped and compared once the clock edge has happened.
module tb_nn_layer_sequencer;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       clear;
      logic       we;
      logic       rdSrc1;
      logic [1:0] rdSrc2;
      logic [1:0] layer;
      logic [8:0] cycle;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       start;
   logic       abort;
   logic       busy;
   logic       done;
   logic [8:0] cycle;
   logic       clear;
   logic       we;
   logic       rdSrc1;
   logic [1:0] rdSrc2;
   logic [1:0] layer;

   int   checks;
   int   errors;
   exp_t expQ[$];

   nn_layer_sequencer #(
      .ADR_LEN      (9),
      .NUM_LAYERS   (3),
      .INPUT_CYCLES (257),
      .HIDDEN_CYCLES(16)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .abort  (abort),
      .busy   (busy),
      .done   (done),
      .cycle  (cycle),
      .clear  (clear),
      .we     (we),
      .rd_src1(rdSrc1),
      .rd_src2(rdSrc2),
      .layer  (layer)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs of an idle sequencer.
   function automatic exp_t idleExp();
      exp_t e;
      e        = '0;
      e.clear  = 1'b1;
      return e;
   endfunction

   // Outputs k cycles after start was sampled, taken from the timeline of
   // one default-parameter inference; anything outside 1..296 is idle.
   function automatic exp_t expInfer(input int k);
      exp_t e;
      e = idleExp();
      if (k == 1 || k == 260 || k == 278) begin
         e.busy  = 1'b1;
         e.clear = 1'b1;
         e.layer = (k == 1) ? 2'd0 : ((k == 260) ? 2'd1 : 2'd2);
      end else if (k >= 2 && k <= 258) begin
         e.busy  = 1'b1;
         e.clear = 1'b0;
         e.cycle = 9'(k - 2);
      end else if (k >= 261 && k <= 276) begin
         e.busy  = 1'b1;
         e.clear = 1'b0;
         e.layer = 2'd1;
         e.cycle = 9'(k - 261);
      end else if (k >= 279 && k <= 294) begin
         e.busy  = 1'b1;
         e.clear = 1'b0;
         e.layer = 2'd2;
         e.cycle = 9'(k - 279);
      end else if (k == 259 || k == 277 || k == 295) begin
         e.busy  = 1'b1;
         e.clear = 1'b0;
         e.we    = 1'b1;
         e.layer = (k == 259) ? 2'd0 : ((k == 277) ? 2'd1 : 2'd2);
      end else if (k == 296) begin
         e.done  = 1'b1;
         e.layer = 2'd2;
      end
      e.rdSrc1 = (e.layer != 2'd0);
      e.rdSrc2 = e.layer;
      return e;
   endfunction

   // Pop the oldest expectation and compare it with the live outputs.
   task automatic checkOutput(input string tag);
      exp_t got;
      exp_t want;
      got = {busy, done, clear, we, rdSrc1, rdSrc2, layer, cycle};
      checks++;
      if (expQ.size() == 0) begin
         errors++;
         $error("[TB] FAIL %s: scoreboard empty, observed %h", tag, got);
      end else begin
         want = expQ.pop_front();
         assert (got === want) else begin
            errors++;
            $error("[TB] FAIL %s: observed busy=%b done=%b clear=%b we=%b src1=%b src2=%0d layer=%0d cycle=%0d expected busy=%b done=%b clear=%b we=%b src1=%b src2=%0d layer=%0d cycle=%0d",
                   tag, got.busy, got.done, got.clear, got.we, got.rdSrc1, got.rdSrc2, got.layer, got.cycle,
                   want.busy, want.done, want.clear, want.we, want.rdSrc1, want.rdSrc2, want.layer, want.cycle);
         end
      end
   endtask

   // Drive one cycle of inputs, queue what should follow the edge, then
   // sample just after the edge.
   task automatic applyStimulus(input logic rst, input logic st, input logic ab,
                                input exp_t e, input string tag);
      reset = rst;
      start = st;
      abort = ab;
      expQ.push_back(e);
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   // Launch one inference and run it to DONE, optionally poking start
   // while the sequencer is busy.
   task automatic runInference(input logic pokeStart, input string tag);
      applyStimulus(1'b0, 1'b1, 1'b0, expInfer(1), $sformatf("%s k=1", tag));
      for (int k = 2; k <= 296; k++) begin
         applyStimulus(1'b0, pokeStart && (k == 101 || k == 281), 1'b0,
                       expInfer(k), $sformatf("%s k=%0d", tag, k));
      end
      applyStimulus(1'b0, 1'b0, 1'b0, idleExp(), $sformatf("%s post", tag));
      applyStimulus(1'b0, 1'b0, 1'b0, idleExp(), $sformatf("%s post2", tag));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      start  = 1'b0;
      abort  = 1'b0;

      // Reset with start held: idle throughout, CLEAR right after release.
      applyStimulus(1'b1, 1'b1, 1'b0, idleExp(), "reset1");
      applyStimulus(1'b1, 1'b1, 1'b0, idleExp(), "reset2");
      reset = 1'b0;
      expQ.push_back(idleExp());
      #1;
      checkOutput("reset release");
      applyStimulus(1'b0, 1'b1, 1'b0, expInfer(1), "start after reset");
      applyStimulus(1'b0, 1'b0, 1'b1, idleExp(), "abort from clear");
      applyStimulus(1'b0, 1'b0, 1'b0, idleExp(), "idle settle");

      // Full inference with a one-cycle start pulse.
      $display("[TB] full inference");
      runInference(1'b0, "full");

      // Start pulses while busy must not disturb or requeue anything.
      $display("[TB] start while busy");
      runInference(1'b1, "busyStart");

      // Reset in the middle of layer 0 discards all progress.
      $display("[TB] reset mid-MAC");
      applyStimulus(1'b0, 1'b1, 1'b0, expInfer(1), "midReset k=1");
      for (int k = 2; k <= 150; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, expInfer(k), $sformatf("midReset k=%0d", k));
      end
      applyStimulus(1'b1, 1'b0, 1'b0, idleExp(), "midReset hit");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, idleExp(), $sformatf("midReset idle%0d", i));
      end

      // Abort during layer-1 WRITE while start is held.
      $display("[TB] abort during write");
      applyStimulus(1'b0, 1'b1, 1'b0, expInfer(1), "abort k=1");
      for (int k = 2; k <= 277; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, expInfer(k), $sformatf("abort k=%0d", k));
      end
      applyStimulus(1'b0, 1'b1, 1'b1, idleExp(), "abort hit");
      applyStimulus(1'b0, 1'b1, 1'b0, expInfer(1), "abort restart");
      applyStimulus(1'b0, 1'b0, 1'b1, idleExp(), "abort cleanup");
      applyStimulus(1'b0, 1'b0, 1'b0, idleExp(), "abort idle");

      // Start held for 700 cycles: inferences repeat every 297 cycles.
      $display("[TB] back-to-back");
      for (int k = 1; k <= 700; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, expInfer(((k - 1) % 297) + 1),
                       $sformatf("b2b k=%0d", k));
      end
      applyStimulus(1'b0, 1'b0, 1'b1, idleExp(), "b2b abort");
      applyStimulus(1'b0, 1'b0, 1'b0, idleExp(), "b2b idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
